// File: rtl/usb_tx_encoder_if.sv
// usb_tx_encoder_if
//   Byte handshake between the TX packet FSM (master) and the USB transmit
//   encoder (slave).
//
//   tx_data   master->slave  byte to send, LSB goes on the line first
//   tx_last   master->slave  tx_data is the final byte of the packet
//   tx_valid  master->slave  tx_data/tx_last are valid
//   tx_ready  slave->master  encoder can take a byte this cycle
interface usb_tx_encoder_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_last,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_last,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
//   USB full-speed transmit encoder. Accepts bytes over a valid/ready
//   handshake into a one-entry holding register, serializes them LSB first at
//   CLKS_PER_BIT clocks per bit, applies bit stuffing and NRZI, drives D+/D-
//   and closes every packet with SE0,SE0,J.
//
//   Optional feature macro: USB_TX_BIT_STUFF_EN
//     defined   - a stuffed 0 follows every STUFF_LIMIT consecutive data 1s
//     undefined - no stuffing; every byte takes exactly 8 bit times
//
//   Ports
//     clk        system clock
//     rst        synchronous, active-high reset
//     tx_bus     slave side of usb_tx_encoder_if (tx_data/tx_last/tx_valid/tx_ready)
//     dp_out     D+ level (registered)
//     dm_out     D- level (registered)
//     tx_busy    packet in progress, including EOP
//     byte_sent  one-cycle strobe on the final cycle of a byte's last bit time
//     tx_error   one-cycle strobe on underrun, coincident with byte_sent
module usb_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned STUFF_LIMIT  = 6
) (
    input  logic            clk,
    input  logic            rst,
    usb_tx_encoder_if.slave tx_bus,
    output logic            dp_out,
    output logic            dm_out,
    output logic            tx_busy,
    output logic            byte_sent,
    output logic            tx_error
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2 || STUFF_LIMIT < 1) begin : g_bad_params
        $error("usb_tx_encoder: CLKS_PER_BIT must be >= 2 and STUFF_LIMIT >= 1");
    end

`ifdef USB_TX_BIT_STUFF_EN
    localparam int unsigned CW = $clog2(STUFF_LIMIT + 1);
    typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP_SE0, EOP_J} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, EOP_SE0, EOP_J} state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;      // data bit index in SEND/STUFF, bit count in EOP_SE0
    logic [6:0]    shift_q, shift_d;  // remaining bits of the byte on the line
    logic          last_q, last_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic          dp_q, dp_d;
    logic          dm_q, dm_d;
`ifdef USB_TX_BIT_STUFF_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_base;
`endif

    logic ready;
    logic accept;
    logic wrap;
    logic take;
    logic next_bit;
    logic byte_end;
    logic goto_eop;
    logic bit_val;

    assign ready           = !hold_full_q && (state_q != EOP_SE0) && (state_q != EOP_J);
    assign tx_bus.tx_ready = ready;
    assign accept          = tx_bus.tx_valid && ready;
    assign wrap            = (timer_q == TW'(CLKS_PER_BIT - 1));

    assign dp_out  = dp_q;
    assign dm_out  = dm_q;
    assign tx_busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            dp_q        <= dp_d;
            dm_q        <= dm_d;
`ifdef USB_TX_BIT_STUFF_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // The line register always holds the level of the bit currently on the
    // bus; the level of the following bit is decided at timer wrap.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        take        = 1'b0;
        next_bit    = 1'b0;
        byte_end    = 1'b0;
        goto_eop    = 1'b0;
        bit_val     = 1'b0;
        byte_sent   = 1'b0;
        tx_error    = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
        cnt_d       = cnt_q;
        cnt_base    = cnt_q;
`endif

        if (state_q != IDLE) begin
            timer_d = wrap ? '0 : timer_q + TW'(1);
        end

        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_bus.tx_data;
            hold_last_d = tx_bus.tx_last;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    take = 1'b1;
`ifdef USB_TX_BIT_STUFF_EN
                    cnt_base = '0;
`endif
                end
            end
            SEND: begin
                if (wrap) begin
`ifdef USB_TX_BIT_STUFF_EN
                    if (cnt_q == CW'(STUFF_LIMIT)) begin
                        state_d = STUFF;
                        dp_d    = dm_q;
                        dm_d    = dp_q;
                        cnt_d   = '0;
                    end else if (bit_q != 3'd7) begin
                        next_bit = 1'b1;
                    end else begin
                        byte_end = 1'b1;
                    end
`else
                    if (bit_q != 3'd7) begin
                        next_bit = 1'b1;
                    end else begin
                        byte_end = 1'b1;
                    end
`endif
                end
            end
`ifdef USB_TX_BIT_STUFF_EN
            STUFF: begin
                // A stuff bit owed after bit 7 still precedes the byte boundary.
                if (wrap) begin
                    state_d = SEND;
                    if (bit_q != 3'd7) begin
                        next_bit = 1'b1;
                    end else begin
                        byte_end = 1'b1;
                    end
                end
            end
`endif
            EOP_SE0: begin
                if (wrap) begin
                    if (bit_q == 3'd1) begin
                        state_d = EOP_J;
                        bit_d   = '0;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (byte_end) begin
            byte_sent = 1'b1;
            if (last_q) begin
                goto_eop = 1'b1;
            end else if (hold_full_q) begin
                take = 1'b1;
            end else begin
                tx_error = 1'b1;
                goto_eop = 1'b1;
            end
        end

        if (goto_eop) begin
            state_d = EOP_SE0;
            bit_d   = '0;
            dp_d    = 1'b0;
            dm_d    = 1'b0;
        end

        if (take) begin
            state_d     = SEND;
            timer_d     = '0;
            bit_d       = '0;
            shift_d     = hold_data_q[7:1];
            last_d      = hold_last_q;
            hold_full_d = 1'b0;
            bit_val     = hold_data_q[0];
        end

        if (next_bit) begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            bit_val = shift_q[0];
        end

        if (take || next_bit) begin
            // NRZI: a 0 swaps J/K, a 1 keeps the current level.
            if (!bit_val) begin
                dp_d = dm_q;
                dm_d = dp_q;
            end
`ifdef USB_TX_BIT_STUFF_EN
            cnt_d = bit_val ? cnt_base + CW'(1) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder
//   Directed bench for usb_tx_encoder. Each accepted byte is expanded by a
//   bit-list model (NRZI, optional stuffing, EOP) into per-bit expectations
//   on a scoreboard queue; a negedge monitor pops one entry per bit time and
//   checks every cycle of it. Stuffing expectations follow USB_TX_BIT_STUFF_EN.
module tb_usb_tx_encoder;

    localparam int unsigned CPB = 8;
    localparam int unsigned SL  = 6;
`ifdef USB_TX_BIT_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] line;  // {dp,dm}
        logic       sent;
        logic       err;
        logic       fin;
    } exp_t;

    logic clk;
    logic rst;
    logic dp_out;
    logic dm_out;
    logic tx_busy;
    logic byte_sent;
    logic tx_error;

    usb_tx_encoder_if bus ();

    usb_tx_encoder #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LIMIT (SL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_bus   (bus),
        .dp_out   (dp_out),
        .dm_out   (dm_out),
        .tx_busy  (tx_busy),
        .byte_sent(byte_sent),
        .tx_error (tx_error)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          exp_start = 0;
    exp_t        sb[$];
    exp_t        cur;
    int unsigned pos       = 0;
    bit          active    = 1'b0;
    bit          idle_chk  = 1'b0;
    bit          m_j       = 1'b1;
    int          m_cnt     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expand one byte into bit-time expectations and push them.
    task automatic model_byte(input logic [7:0] d, input logic l, input logic e);
        exp_t loc [10];
        exp_t x;
        int   n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!d[i]) begin
                m_j   = !m_j;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            x.line = m_j ? 2'b10 : 2'b01;
            x.sent = 1'b0;
            x.err  = 1'b0;
            x.fin  = 1'b0;
            loc[n] = x;
            n++;
            if (STUFF_ON && m_cnt == SL) begin
                m_j    = !m_j;
                m_cnt  = 0;
                x.line = m_j ? 2'b10 : 2'b01;
                loc[n] = x;
                n++;
            end
        end
        loc[n-1].sent = 1'b1;
        loc[n-1].err  = e;
        for (int i = 0; i < n; i++) sb.push_back(loc[i]);
        if (l || e) begin
            x.line = 2'b00;
            x.sent = 1'b0;
            x.err  = 1'b0;
            x.fin  = 1'b0;
            sb.push_back(x);
            sb.push_back(x);
            x.line = 2'b10;
            x.fin  = 1'b1;
            sb.push_back(x);
            m_j   = 1'b1;
            m_cnt = 0;
        end
    endtask

    // Entered and left at posedge+2. tx_valid is dropped on return; a
    // following call in the same time step keeps it high without a gap.
    task automatic send_byte(input logic [7:0] d, input logic l, input logic e, input bit first);
        bit got = 1'b0;
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 400 && !got; k++) begin
            got = bus.tx_ready;
            @(posedge clk);
            #2;
        end
        chk("accept", {31'd0, got}, 32'd1);
        if (first) exp_start = cyc + 1;
        model_byte(d, l, e);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk);
            #2;
            done = !active && !idle_chk && (sb.size() == 0) && !tx_busy;
        end
        chk("packet_done", {31'd0, done}, 32'd1);
    endtask

    // Line monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                active   = 1'b0;
                idle_chk = 1'b0;
                pos      = 0;
            end else begin
                if (idle_chk) begin
                    chk("eop_end_busy", tx_busy, 0);
                    chk("eop_end_ready", bus.tx_ready, 1);
                    idle_chk = 1'b0;
                end
                if (!active && tx_busy) begin
                    active = 1'b1;
                    pos    = 0;
                    chk("start_cycle", cyc, exp_start);
                end
                if (active) begin
                    if (pos == 0) begin
                        checks++;
                        assert (sb.size() != 0) else begin
                            failures++;
                            $error("FAIL sb_empty observed=%0d expected=nonzero", sb.size());
                        end
                        if (sb.size() == 0) active = 1'b0;
                        else cur = sb.pop_front();
                    end
                    if (active) begin
                        chk("line", {30'd0, dp_out, dm_out}, {30'd0, cur.line});
                        chk("busy", tx_busy, 1);
                        chk("byte_sent", byte_sent, ((pos == CPB - 1) && cur.sent) ? 1 : 0);
                        chk("tx_error", tx_error, ((pos == CPB - 1) && cur.err) ? 1 : 0);
                        if (cur.line == 2'b00 || cur.fin) chk("eop_ready", bus.tx_ready, 0);
                        pos++;
                        if (pos == CPB) begin
                            pos = 0;
                            if (cur.fin) begin
                                active   = 1'b0;
                                idle_chk = 1'b1;
                            end
                        end
                    end
                end else begin
                    chk("idle_line", {30'd0, dp_out, dm_out}, 2'b10);
                    chk("idle_strobes", {30'd0, byte_sent, tx_error}, 0);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int acc1;
        rst          = 1'b1;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        chk("rst_dp", dp_out, 1);
        chk("rst_dm", dm_out, 0);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_byte_sent", byte_sent, 0);
        chk("rst_tx_error", tx_error, 0);

        // Single byte packet
        send_byte(8'h80, 1'b1, 1'b0, 1'b1);
        wait_done();

        // Six ones then stuffing (when enabled), stuff counter carries on
        send_byte(8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        wait_done();

        // Back-to-back with tx_valid held high
        send_byte(8'h00, 1'b0, 1'b0, 1'b1);
        acc1 = cyc;
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        chk("holdfree_accept", cyc - acc1, 2);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        wait_done();

        // Underrun
        send_byte(8'h55, 1'b0, 1'b1, 1'b1);
        wait_done();

        // Reset during bit 3
        send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (27) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst   = 1'b0;
        m_j   = 1'b1;
        m_cnt = 0;
        chk("midrst_dp", dp_out, 1);
        chk("midrst_dm", dm_out, 0);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_ready", bus.tx_ready, 1);
        repeat (4 * CPB) begin
            @(posedge clk);
            #2;
        end
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_line", {30'd0, dp_out, dm_out}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

USB full-speed transmit encoder. It takes bytes from the packet-building logic over a valid/ready handshake and serializes them LSB-first at CLKS_PER_BIT clocks per bit. It performs bit stuffing and NRZI encoding, drives the D+/D- line levels, and closes each packet with an EOP. It is the transmit-side counterpart of the receive timer/decoder path and sits between the TX packet FSM and the bus driver pads.

## Interface
- CLKS_PER_BIT, 8, clocks per USB bit time (≥ 2)
- STUFF_LIMIT, 6, consecutive data 1s that force a stuffed 0

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send; SYNC and PID are supplied as ordinary bytes by upstream
- tx_last  in  1  qualifies tx_data as final byte of packet
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  holding register empty and no EOP in progress
- dp_out  out  1  D+ level
- dm_out  out  1  D- level
- tx_busy  out  1  packet in progress, including EOP
- byte_sent  out  1  one-cycle strobe per byte fully on the line
- tx_error  out  1  one-cycle strobe on underrun

## Operation
- Reset values: dp_out=1, dm_out=0 (J), tx_ready=1, tx_busy=0, byte_sent=0, tx_error=0. The holding register, shifter, bit timer and stuff counter are all cleared.
- Holding register: one byte plus its last flag.
  - Loads on tx_valid & tx_ready.
  - Frees when the shifter takes its contents.
- States: IDLE, SEND, STUFF, EOP_SE0, EOP_J.
- IDLE: line held at J. When the holding register is full, the shifter loads, the stuff counter clears, and the block enters SEND.
- SEND: one data bit per bit time, LSB first.
  - NRZI: a data 0 toggles the line between J (1,0) and K (0,1); a data 1 holds the line.
  - Stuff counter increments on a data 1 and clears on a data 0.
  - When it reaches STUFF_LIMIT, the next bit time is STUFF.
  - The stuff counter carries across byte boundaries.
- STUFF: one bit time with a toggle (stuffed 0). Counter clears, then the block returns to SEND or proceeds to the byte/packet-end decision. A stuff bit owed after the final data bit is still sent before the EOP.
- Byte boundary, at the end of bit 7 plus any owed stuff bit:
  - byte_sent pulses.
  - If the byte's last flag is set → EOP_SE0.
  - Else if the holding register is full → load it and continue SEND with no gap.
  - Else → underrun: tx_error pulses and the block goes to EOP_SE0.
- EOP_SE0: dp_out=0, dm_out=0 for 2 bit times. Then EOP_J: J for 1 bit time, then IDLE.
- tx_busy: high from the cycle after the IDLE→SEND load until the IDLE return; low in IDLE.
- tx_ready: low when the holding register is full or the state is EOP_SE0/EOP_J.
- rst asserted mid-operation: the next cycle is the reset state. No EOP is sent; the pending byte is dropped.

## Timing
- Byte accepted at cycle t with the block idle: the first bit level is on dp/dm from cycle t+2.
- Every bit, including stuff and EOP bits, is held exactly CLKS_PER_BIT cycles.
- The bit timer counts 0..CLKS_PER_BIT-1. Line transitions occur only at bit timer wrap.
- dp_out/dm_out are registered: no combinational path from inputs.
- byte_sent and tx_error assert on the final cycle of the byte's last bit time.
- Byte with no stuffing = 8×CLKS_PER_BIT cycles. Each stuff bit adds CLKS_PER_BIT cycles. EOP = 3×CLKS_PER_BIT cycles.
- A tx_valid arriving in the same cycle the shifter frees the holding register is accepted in the next cycle.

## Configuration
- USB_TX_BIT_STUFF_EN defined: stuffing as described.
- Undefined: the stuff counter and STUFF state are removed, and bytes always take 8 bit times. Used for raw line-pattern test modes.

## Test plan
- Reset, send 0x80 with last:
  - dp per bit 0,1,0,1,0,1,0,0 (dm complement).
  - Then SE0 for 16 cycles, then J for 8 cycles.
  - tx_busy high for 88 cycles; byte_sent at cycle 64 of transmission.
- 0xFF then 0x00 (last), with USB_TX_BIT_STUFF_EN: stuff toggle after the 6th one; first byte_sent after 72 cycles, second after a further 64.
- Same stimulus without USB_TX_BIT_STUFF_EN: no stuff bit; byte_sent strobes at 64 and 128 cycles.
- Three 0x00 bytes back-to-back with tx_valid held high, last on the third: continuous toggling, byte_sent every 64 cycles, no idle gap, single EOP.
- Single 0x55 without last, tx_valid then low: tx_error and byte_sent pulse together at cycle 64, followed by EOP; tx_ready returns high on IDLE.
- rst pulsed during bit 3 of a byte: next cycle dp_out=1, dm_out=0, tx_busy=0, tx_ready=1; no EOP emitted.
